board_mem_resp: RTL and testbench
=================================

Name: board_mem_resp

Overview:
- Playfield storage responder; serves the read/write cell transactions issued by line-clear, piece-lock and render engines.
- Holds a ROWS x COLS array of CELL_W-bit cells. 0 means empty; 1..7 is a piece type.
- Maintains per-row occupancy counters and drives the line_full vector consumed by the line-clear engine.
- Supports a multi-cycle whole-board wipe for game restart.

Parameters:
- ROWS, 20, number of board rows (pos_i range 0..ROWS-1).
- COLS, 10, number of board columns (pos_j range 0..COLS-1).
- CELL_W, 3, bits per cell.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req  in  1  transaction request, sampled each rising edge.
- read  in  1  1 = read, 0 = write; qualified by req.
- pos_i  in  5  row address.
- pos_j  in  5  column address.
- write_data  in  CELL_W  value to write.
- board_clear  in  1  start a whole-board wipe (pulse).
- read_data  out  CELL_W  registered read result.
- rd_valid  out  1  one-cycle pulse when read_data is valid.
- ack  out  1  one-cycle pulse; request accepted and completed.
- busy  out  1  high while a wipe is in progress.
- line_full  out  ROWS  bit [0:ROWS-1]; bit r set when all COLS cells of row r are nonzero.

Behaviour:
- Reset (async, active-high): all cells 0, all row counters 0, line_full = 0, read_data = 0, rd_valid = 0, ack = 0, busy = 0, FSM = IDLE.
- FSM states are IDLE and WIPE.
- IDLE to WIPE: board_clear = 1 at an edge.
  - The wipe row counter loads 0 and busy rises on that edge.
  - A req sampled on that same edge is dropped: no ack, no access.
- WIPE: each cycle, zero every cell of row wipe_row and its counter, then increment wipe_row. After row ROWS-1 is wiped, go to IDLE and drop busy.
  - Total is exactly ROWS cycles of busy (20 by default).
  - req and board_clear are ignored while busy: no ack.
- Accepted request (IDLE, no board_clear, address in range): ack is 1 on the following cycle, exactly 1 cycle wide; back-to-back requests give back-to-back acks.
- Read: read_data gets cell[pos_i][pos_j] and rd_valid pulses together with ack, a latency of 1 cycle. read_data holds its value until the next read.
- Write: cell gets write_data; the row counter and line_full update on the same edge; ack follows on the next cycle.
  - Counter rule: old = 0 and new != 0 gives +1; old != 0 and new = 0 gives -1; otherwise unchanged.
  - Counter is 4 bits and never leaves 0..COLS.
- line_full[r] = (count[r] == COLS), registered alongside the counter. It is visible to the requester no later than the edge that raises ack.
- Read of an address written the previous cycle returns the new value (write-through ordering).
- Out-of-range address (pos_i >= ROWS or pos_j >= COLS): no storage or counter change, read_data unchanged, rd_valid = 0, ack still pulses so requesters never hang.
- Reset mid-wipe aborts immediately: the result is the full reset state.
- board_clear asserted while already busy is ignored; the wipe does not restart.

Optional Feature:
- Macro: BOARD_MEM_OOB_ERR_EN.
- Defined:
  - Adds output addr_err (1 bit), cleared by reset or board_clear.
  - addr_err is set sticky on the ack edge of any out-of-range request.
  - The same request also forces read_data to 0 with rd_valid = 1 for out-of-range reads.
- Undefined: no addr_err port; out-of-range behaviour as in Behaviour.

Test Plan:
- Reset then read (4,7) gives ack = 1 and rd_valid = 1 one cycle after req, read_data = 0, line_full = 0.
- Write 3'd3 to (19,0..9), one per cycle: line_full[19] = 0 after 9 writes and 1 by the ack of the 10th; line_full[0:18] = 0.
- With row 19 full, write 3'd0 to (19,5): line_full[19] returns to 0. Then write 3'd5 to (19,5) and 3'd2 to (19,5) again: the counter stays at 10 and line_full[19] = 1.
- Write 3'd6 to (2,2) then read (2,2) on the next cycle: read_data = 6.
- Fill rows 0 and 19, then pulse board_clear together with a req:
  - busy is high for exactly 20 cycles and the req gets no ack.
  - Reqs during busy get no ack.
  - Afterwards line_full = 0 and a read of (0,0) returns 0.
- Write to (20,3) and (5,10): ack pulses and no cell changes. With BOARD_MEM_OOB_ERR_EN, addr_err = 1 until board_clear.

Source files
------------

// File: rtl/board_mem_resp_if.sv
// board_mem_resp_if: cell transaction bus between board engines and the playfield store.
// Carries addr_err only when BOARD_MEM_OOB_ERR_EN is defined.
interface board_mem_resp_if #(
  parameter int ROWS   = 20,
  parameter int CELL_W = 3
);
  logic              req;
  logic              read;
  logic [4:0]        pos_i;
  logic [4:0]        pos_j;
  logic [CELL_W-1:0] write_data;
  logic              board_clear;
  logic [CELL_W-1:0] read_data;
  logic              rd_valid;
  logic              ack;
  logic              busy;
  logic [0:ROWS-1]   line_full;
`ifdef BOARD_MEM_OOB_ERR_EN
  logic              addr_err;
`endif
  modport master (
    output req, read, pos_i, pos_j, write_data, board_clear,
`ifdef BOARD_MEM_OOB_ERR_EN
    input  addr_err,
`endif
    input  read_data, rd_valid, ack, busy, line_full
  );
  modport slave (
    input  req, read, pos_i, pos_j, write_data, board_clear,
`ifdef BOARD_MEM_OOB_ERR_EN
    output addr_err,
`endif
    output read_data, rd_valid, ack, busy, line_full
  );
endinterface

// File: rtl/board_mem_resp.sv
// board_mem_resp: playfield cell store with per-row occupancy, line_full and multi-cycle wipe.
// Optional sticky out-of-range flag addr_err when BOARD_MEM_OOB_ERR_EN is defined.
module board_mem_resp #(
  parameter int ROWS   = 20,
  parameter int COLS   = 10,
  parameter int CELL_W = 3
) (
  input logic             clk,
  input logic             reset,
  board_mem_resp_if.slave bus
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WIPE = 1'b1;
  localparam logic [4:0] ROWS5 = 5'(ROWS);
  localparam logic [4:0] COLS5 = 5'(COLS);
  localparam logic [3:0] FULL = 4'(COLS);
  logic [0:0]        state_q, state_d;
  logic [4:0]        wipe_row_q, wipe_row_d;
  logic [CELL_W-1:0] cell_q [ROWS][COLS];
  logic [CELL_W-1:0] cell_d [ROWS][COLS];
  logic [3:0]        cnt_q [ROWS];
  logic [3:0]        cnt_d [ROWS];
  logic [0:ROWS-1]   line_full_q, line_full_d;
  logic [CELL_W-1:0] read_data_q, read_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic              acc, in_range, wr;
  assign acc      = (state_q == IDLE) && !bus.board_clear && bus.req;
  assign in_range = (bus.pos_i < ROWS5) && (bus.pos_j < COLS5);
  assign wr       = acc && in_range && !bus.read;
  always_comb begin
    state_d     = state_q;
    wipe_row_d  = wipe_row_q;
    cell_d      = cell_q;
    cnt_d       = cnt_q;
    read_data_d = read_data_q;
    ack_d       = acc;
    rd_valid_d  = acc && in_range && bus.read;
    if (state_q == IDLE) begin
      state_d    = bus.board_clear ? WIPE : IDLE;
      wipe_row_d = bus.board_clear ? 5'd0 : wipe_row_q;
    end else begin
      state_d    = (wipe_row_q == ROWS5 - 5'd1) ? IDLE : WIPE;
      wipe_row_d = wipe_row_q + 5'd1;
    end
    for (int r = 0; r < ROWS; r++) begin
      for (int c = 0; c < COLS; c++) begin
        if (bus.pos_i == 5'(r) && bus.pos_j == 5'(c)) begin
          if (acc && bus.read) read_data_d = cell_q[r][c];
          if (wr) begin
            cell_d[r][c] = bus.write_data;
            cnt_d[r] = (cell_q[r][c] == '0 && bus.write_data != '0) ? cnt_q[r] + 4'd1 :
                       (cell_q[r][c] != '0 && bus.write_data == '0) ? cnt_q[r] - 4'd1 : cnt_q[r];
          end
        end
        if (state_q == WIPE && wipe_row_q == 5'(r)) cell_d[r][c] = '0;
      end
      if (state_q == WIPE && wipe_row_q == 5'(r)) cnt_d[r] = 4'd0;
      line_full_d[r] = (cnt_d[r] == FULL);
    end
`ifdef BOARD_MEM_OOB_ERR_EN
    if (acc && !in_range && bus.read) begin
      read_data_d = '0;
      rd_valid_d  = 1'b1;
    end
    err_d = bus.board_clear ? 1'b0 : (err_q || (acc && !in_range));
`else
    err_d = 1'b0;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      wipe_row_q  <= 5'd0;
      line_full_q <= '0;
      read_data_q <= '0;
      rd_valid_q  <= 1'b0;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      for (int r = 0; r < ROWS; r++) begin
        cnt_q[r] <= 4'd0;
        for (int c = 0; c < COLS; c++) cell_q[r][c] <= '0;
      end
    end else begin
      state_q     <= state_d;
      wipe_row_q  <= wipe_row_d;
      line_full_q <= line_full_d;
      read_data_q <= read_data_d;
      rd_valid_q  <= rd_valid_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      cell_q      <= cell_d;
    end
  end
  assign bus.read_data = read_data_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.ack       = ack_q;
  assign bus.busy      = (state_q == WIPE);
  assign bus.line_full = line_full_q;
`ifdef BOARD_MEM_OOB_ERR_EN
  assign bus.addr_err  = err_q;
`else
  logic unused_err;
  assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_board_mem_resp.sv
// tb_board_mem_resp: directed plan plus randomized transactions against a board-array reference model.
module tb_board_mem_resp;
`ifdef BOARD_MEM_OOB_ERR_EN
  localparam bit OOB_EN = 1'b1;
`else
  localparam bit OOB_EN = 1'b0;
`endif
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   vectors = 0;
  int   errs = 0;
  int   mdl [20][10];
  int   exp_rd = 0;
  bit   exp_err = 1'b0;
  board_mem_resp_if #(.ROWS(20), .CELL_W(3)) bus ();
  board_mem_resp #(.ROWS(20), .COLS(10), .CELL_W(3)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [0:19] full_vec();
    logic [0:19] v;
    for (int r = 0; r < 20; r++) begin
      int n = 0;
      for (int c = 0; c < 10; c++) if (mdl[r][c] != 0) n++;
      v[r] = (n == 10);
    end
    return v;
  endfunction
  task automatic clear_model();
    for (int r = 0; r < 20; r++) for (int c = 0; c < 10; c++) mdl[r][c] = 0;
  endtask
  task automatic check_err();
`ifdef BOARD_MEM_OOB_ERR_EN
    check("addr_err", 32'(bus.addr_err), 32'(exp_err));
`endif
  endtask
  task automatic op(input bit rd, input int i, input int j, input int wd);
    bit inr;
    bus.req = 1'b1; bus.read = rd; bus.pos_i = 5'(i); bus.pos_j = 5'(j); bus.write_data = 3'(wd);
    @(posedge clk); #1;
    bus.req = 1'b0;
    inr = (i < 20) && (j < 10);
    if (inr && !rd) mdl[i][j] = wd;
    if (inr && rd) exp_rd = mdl[i][j];
    if (!inr && rd && OOB_EN) exp_rd = 0;
    if (!inr && OOB_EN) exp_err = 1'b1;
    check("ack", 32'(bus.ack), 32'd1);
    check("rd_valid", 32'(bus.rd_valid), 32'(rd && (inr || OOB_EN)));
    check("read_data", 32'(bus.read_data), 32'(exp_rd));
    check("line_full", 32'(bus.line_full), 32'(full_vec()));
    check("busy", 32'(bus.busy), 32'd0);
    check_err();
  endtask
  task automatic idle();
    @(posedge clk); #1;
    check("idle_ack", 32'(bus.ack), 32'd0);
    check("idle_rd_valid", 32'(bus.rd_valid), 32'd0);
  endtask
  task automatic wipe(input bit with_req);
    int n;
    bus.board_clear = 1'b1; bus.req = with_req; bus.read = 1'b0;
    bus.pos_i = 5'd3; bus.pos_j = 5'd3; bus.write_data = 3'd7;
    @(posedge clk); #1;
    bus.board_clear = 1'b0;
    clear_model();
    exp_err = 1'b0;
    check("wipe_busy_rise", 32'(bus.busy), 32'd1);
    check("wipe_req_dropped", 32'(bus.ack), 32'd0);
    n = 1;
    while (bus.busy && n < 100) begin
      bus.req = 1'b1; bus.read = 1'($urandom); bus.board_clear = 1'($urandom);
      @(posedge clk); #1;
      check("busy_ack", 32'(bus.ack), 32'd0);
      if (bus.busy) n++;
    end
    bus.req = 1'b0; bus.board_clear = 1'b0;
    check("busy_cycles", 32'(n), 32'd20);
    check("wipe_line_full", 32'(bus.line_full), 32'd0);
    check_err();
  endtask
  initial begin
    clear_model();
    bus.req = 1'b0; bus.read = 1'b0; bus.pos_i = '0; bus.pos_j = '0;
    bus.write_data = '0; bus.board_clear = 1'b0;
    #12;
    check("rst_ack", 32'(bus.ack), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_read_data", 32'(bus.read_data), 32'd0);
    check("rst_line_full", 32'(bus.line_full), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    op(1, 4, 7, 0);
    for (int c = 0; c < 10; c++) begin
      op(0, 19, c, 3);
      check("row19_full", 32'(bus.line_full[19]), 32'(c == 9));
    end
    op(0, 19, 5, 0);
    check("row19_cleared_cell", 32'(bus.line_full[19]), 32'd0);
    op(0, 19, 5, 5);
    op(0, 19, 5, 2);
    check("row19_rewrite", 32'(bus.line_full[19]), 32'd1);
    op(0, 2, 2, 6);
    op(1, 2, 2, 0);
    check("write_through", 32'(bus.read_data), 32'd6);
    idle();
    for (int c = 0; c < 10; c++) op(0, 0, c, c + 1 > 7 ? 7 : c + 1);
    check("row0_full", 32'(bus.line_full[0]), 32'd1);
    wipe(1'b1);
    op(1, 0, 0, 0);
    check("wiped_cell", 32'(bus.read_data), 32'd0);
    op(1, 19, 9, 0);
    op(0, 5, 9, 4);
    op(0, 20, 3, 1);
    op(0, 5, 10, 1);
    op(1, 5, 9, 0);
    check("oob_no_change", 32'(bus.read_data), 32'd4);
    op(1, 25, 1, 0);
    idle();
    check_err();
    wipe(1'b0);
    for (int c = 0; c < 10; c++) op(0, 7, c, 1);
    bus.board_clear = 1'b1;
    @(posedge clk); #1 bus.board_clear = 1'b0;
    repeat (4) @(posedge clk);
    #2 reset = 1'b1;
    #1;
    clear_model(); exp_rd = 0; exp_err = 1'b0;
    check("mid_wipe_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_wipe_rst_lf", 32'(bus.line_full), 32'd0);
    check("mid_wipe_rst_rd", 32'(bus.read_data), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    op(1, 7, 3, 0);
    for (int k = 0; k < 400; k++) begin
      int sel = int'($urandom_range(0, 59));
      if (sel == 0) wipe(1'($urandom));
      else if (sel < 4) idle();
      else begin
        int i = ($urandom_range(0, 9) == 0) ? int'($urandom_range(20, 31)) : int'($urandom_range(0, 3));
        int j = int'($urandom_range(0, 10));
        op(1'($urandom_range(0, 2) == 0), i, j, int'($urandom_range(0, 7)));
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
